// File: rtl/cpeta_error_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpeta_error_monitor                                                      |
// | Accumulates error-distance statistics of an approximate adder per run.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cpeta_error_monitor #(
  parameter int N  = 16,
  parameter int CW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CW-1:0]     num_samples,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      a,
  input  logic [N-1:0]      b,
  input  logic [N-1:0]      approx_sum,
  output logic              busy,
  output logic              done,
  output logic [CW-1:0]     err_count,
  output logic [N:0]        max_ed,
  output logic [N+CW:0]     sum_ed
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_nsamp;
  logic [CW-1:0]   r_count;
  logic            r_s1_valid;
  logic [N:0]      r_s1_ed;
  logic [CW-1:0]   r_err_count;
  logic [N:0]      r_max_ed;
  logic [N+CW:0]   r_sum_ed;

  logic [N:0]      w_exact;
  logic [N:0]      w_apx;
  logic [N:0]      w_ed;
  logic            w_room;
  logic            w_accept;
  logic            w_last;
  logic            w_start_acc;

  // The carry-out of a+b is kept so wrap-around errors are measured exactly.
  assign w_exact     = {1'b0, a} + {1'b0, b};
  assign w_apx       = {1'b0, approx_sum};
  assign w_ed        = (w_exact >= w_apx) ? (w_exact - w_apx) : (w_apx - w_exact);

  assign w_room      = (r_count < r_nsamp);
  assign w_accept    = in_valid && in_ready;
  assign w_last      = w_accept && (r_count == (r_nsamp - CW'(1)));
  assign w_start_acc = (r_state == IDLE) && start;

  assign err_count   = r_err_count;
  assign max_ed      = r_max_ed;
  assign sum_ed      = r_sum_ed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = RUN;
        end
      end
      RUN: begin
        in_ready = w_room;
        busy     = 1'b1;
        // A zero-length run leaves immediately since there is never room.
        if (w_last || !w_room) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (!r_s1_valid) begin
          w_next = FIN;
        end
      end
      FIN: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nsamp     <= '0;
      r_count     <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_ed     <= '0;
      r_err_count <= '0;
      r_max_ed    <= '0;
      r_sum_ed    <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_ed <= w_ed;
        r_count <= r_count + CW'(1);
      end
      if (w_start_acc) begin
        r_nsamp     <= num_samples;
        r_count     <= '0;
        r_err_count <= '0;
        r_max_ed    <= '0;
        r_sum_ed    <= '0;
      end else if (r_s1_valid) begin
        r_sum_ed    <= r_sum_ed + {{CW{1'b0}}, r_s1_ed};
        r_err_count <= r_err_count + CW'(r_s1_ed != '0);
        if (r_s1_ed > r_max_ed) begin
          r_max_ed <= r_s1_ed;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpeta_error_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cpeta_error_monitor                                                   |
// | Table-driven, scoreboarded bench for cpeta_error_monitor.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_cpeta_error_monitor;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] ap;
    logic [16:0] ed;
  } vec_t;

  typedef struct {
    logic [15:0] err;
    logic [16:0] max;
    logic [32:0] sum;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] num_samples;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] approx_sum;
  logic        busy;
  logic        done;
  logic [15:0] err_count;
  logic [16:0] max_ed;
  logic [32:0] sum_ed;

  vec_t vt [8];
  exp_t sb [$];
  int   n_vec;
  int   n_mis;
  int   n_acc;
  int   n_done;

  cpeta_error_monitor #(.N(16), .CW(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_samples (num_samples),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .approx_sum  (approx_sum),
    .busy        (busy),
    .done        (done),
    .err_count   (err_count),
    .max_ed      (max_ed),
    .sum_ed      (sum_ed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accepts are counted half a cycle before the edge that takes them.
  always @(negedge clk) begin
    if (in_valid && in_ready) n_acc++;
    if (done) n_done++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_mis++;
    $display("FAIL %s: got timeout/missing required event", nm);
  endtask

  task automatic start_run(input logic [15:0] n);
    start       = 1'b1;
    num_samples = n;
    tick();
    start       = 1'b0;
    num_samples = 16'hFFFF;
    chk("busy_run", busy, 1);
  endtask

  task automatic send(input int i, input int gaps, output int stalls);
    in_valid = 1'b0;
    repeat (gaps) tick();
    a          = vt[i].a;
    b          = vt[i].b;
    approx_sum = vt[i].ap;
    in_valid   = 1'b1;
    stalls     = 0;
    while (!in_ready && stalls < 20) begin
      tick();
      stalls++;
    end
    if (!in_ready) fail("accept_timeout");
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_run(input int ids[$]);
    exp_t e;
    e.err = '0;
    e.max = '0;
    e.sum = '0;
    foreach (ids[k]) begin
      if (vt[ids[k]].ed != 0) e.err++;
      if (vt[ids[k]].ed > e.max) e.max = vt[ids[k]].ed;
      e.sum = e.sum + 33'(vt[ids[k]].ed);
    end
    sb.push_back(e);
  endtask

  // Called right after the final accept (or after start for an empty run).
  task automatic wait_done();
    exp_t e;
    tick();
    chk("done_early", done, 0);
    tick();
    chk("done_t2", done, 1);
    chk("busy_fin", busy, 0);
    if (sb.size() == 0) begin
      fail("scoreboard_empty");
    end else begin
      e = sb.pop_front();
      chk("err_count", err_count, e.err);
      chk("max_ed", max_ed, e.max);
      chk("sum_ed", sum_ed, e.sum);
      tick();
      chk("done_once", done, 0);
      chk("hold_sum", sum_ed, e.sum);
      chk("hold_err", err_count, e.err);
    end
  endtask

  task automatic run_list(input int ids[$]);
    int st;
    start_run(16'(ids.size()));
    expect_run(ids);
    foreach (ids[k]) send(ids[k], 0, st);
    wait_done();
  endtask

  initial begin
    int st;
    int acc0;
    int q[$];
    n_vec = 0; n_mis = 0;
    vt[0] = '{16'h1234, 16'h5678, 16'h68AC, 17'd0};
    vt[1] = '{16'hFFFF, 16'h0001, 16'h0000, 17'd65536};
    vt[2] = '{16'hAAAA, 16'h5555, 16'hFFFE, 17'd1};
    vt[3] = '{16'h0F0F, 16'hF0F0, 16'h0000, 17'd65535};
    vt[4] = '{16'h0000, 16'h0000, 16'hFFFF, 17'd65535};
    vt[5] = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 17'd65536};
    vt[6] = '{16'h0001, 16'h0001, 16'h0005, 17'd3};
    vt[7] = '{16'h8000, 16'h8000, 16'hFFFF, 17'd1};

    rst = 1'b1; start = 1'b0; num_samples = '0; in_valid = 1'b0;
    a = '0; b = '0; approx_sum = '0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_err", err_count, 0);
    chk("rst_sum", sum_ed, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      q = '{i};
      run_list(q);
    end

    // Back-to-back: every sample must be taken with no stall cycles.
    start_run(16'd8);
    q = '{0, 1, 2, 3, 4, 5, 6, 7};
    expect_run(q);
    for (int i = 0; i < 8; i++) begin
      send(i, 0, st);
      chk("b2b_stall", st, 0);
    end
    wait_done();

    q = '{1, 2};
    run_list(q);

    // Empty run.
    acc0 = n_acc;
    start_run(16'd0);
    chk("zero_ready", in_ready, 0);
    q = '{};
    expect_run(q);
    wait_done();
    chk("zero_accepts", n_acc - acc0, 0);

    // Gaps plus a stray start mid-run.
    acc0 = n_acc;
    start_run(16'd3);
    q = '{0, 1, 2};
    expect_run(q);
    send(0, 2, st);
    start = 1'b1; num_samples = 16'd1;
    send(1, 1, st);
    start = 1'b0;
    send(2, 3, st);
    chk("gap_ready_after", in_ready, 0);
    in_valid = 1'b1;
    wait_done();
    in_valid = 1'b0;
    chk("gap_accepts", n_acc - acc0, 3);

    // Reset while draining.
    acc0 = n_done;
    start_run(16'd2);
    q = '{1, 3};
    expect_run(q);
    send(1, 0, st);
    send(3, 0, st);
    chk("drain_busy", busy, 1);
    void'(sb.pop_back());
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_err", err_count, 0);
    chk("arst_max", max_ed, 0);
    chk("arst_sum", sum_ed, 0);
    repeat (3) tick();
    chk("arst_no_done", n_done - acc0, 0);
    rst = 1'b0;
    q = '{3, 6};
    run_list(q);

    chk("done_pulses", n_done, 13);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpeta_error_monitor.md
CPETA_ERROR_MONITOR -- requirements
Module: cpeta_error_monitor

Interface
REQ-001 SHALL have parameter N, default 16, meaning operand/approximate-sum width.
REQ-002 SHALL have parameter CW, default 16, meaning sample-count width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  begin a measurement run (level sampled per cycle).
REQ-006 SHALL have port num_samples  input  CW  samples in the run, captured on accepted start.
REQ-007 SHALL have port in_valid  input  1  sample present on a/b/approx_sum.
REQ-008 SHALL have port in_ready  output  1  monitor accepts a sample this cycle.
REQ-009 SHALL have port a  input  N  operand A as applied to the approximate adder.
REQ-010 SHALL have port b  input  N  operand B as applied to the approximate adder.
REQ-011 SHALL have port approx_sum  input  N  approximate adder output (N bits, no carry-out).
REQ-012 SHALL have port busy  output  1  run in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse, statistics final.
REQ-014 SHALL have port err_count  output  CW  samples with nonzero error distance.
REQ-015 SHALL have port max_ed  output  N+1  largest error distance in run.
REQ-016 SHALL have port sum_ed  output  N+1+CW  sum of error distances in run (cannot overflow).

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DRAIN, FIN; reset state IDLE.
REQ-018 SHALL, in IDLE with start=1, capture num_samples, clear err_count/max_ed/sum_ed/accepted-count, go to RUN; start in any other state ignored.
REQ-019 SHALL, when captured num_samples=0, go RUN->DRAIN at the next edge without accepting samples.
REQ-020 SHALL drive in_ready=1 only in RUN while accepted-count < captured num_samples; 0 in all other states.
REQ-021 SHALL accept a sample on an edge where in_valid=1 and in_ready=1; in_valid without in_ready has no effect and does not need to be held.
REQ-022 SHALL, in stage 1 (accept edge t), register exact = a+b zero-extended to N+1 bits and ed = |exact - {1'b0,approx_sum}|.
REQ-023 SHALL, in stage 2 (edge t+1), update sum_ed += ed, max_ed = max(max_ed, ed), err_count += (ed != 0).
REQ-024 SHALL go RUN->DRAIN on the edge accepting the final sample; DRAIN holds until the stage-1 and stage-2 pipelines are empty.
REQ-025 SHALL assert done for exactly one cycle in FIN, beginning 2 edges after the final accept (t+2); FIN->IDLE next edge.
REQ-026 SHALL drive busy=1 in RUN and DRAIN, 0 in IDLE and FIN.
REQ-027 SHALL hold err_count/max_ed/sum_ed constant from done until the next accepted start.
REQ-028 SHALL sustain one accepted sample per cycle in RUN (back-to-back in_valid).
REQ-029 SHALL compute ed exactly for wrap-around cases (exact >= 2^N); the carry-out is part of exact.

Reset
REQ-030 SHALL on rst=1, asynchronously and regardless of state: state IDLE, in_ready=0, busy=0, done=0, err_count=0, max_ed=0, sum_ed=0, pipeline valids=0.
REQ-031 SHALL discard a run interrupted by rst; no done pulse for it.
REQ-032 SHALL accept start in the first cycle after rst deasserts.

Verification
REQ-033 SHALL cover: start, num_samples=1; a=16'h1234,b=16'h5678,approx_sum=16'h68AC -> done at t+2, err_count=0, max_ed=0, sum_ed=0.
REQ-034 SHALL cover: num_samples=2, back-to-back a=16'hFFFF,b=16'h0001,approx=16'h0000 then a=16'hAAAA,b=16'h5555,approx=16'hFFFE -> ed 65536 and 1; err_count=2, max_ed=17'h10000, sum_ed=65537.
REQ-035 SHALL cover: num_samples=0 -> in_ready never 1, done pulses once, all statistics 0.
REQ-036 SHALL cover: num_samples=3 with in_valid gaps and a start pulse mid-run -> start ignored, exactly 3 accepts, in_ready=0 after third.
REQ-037 SHALL cover: rst asserted in DRAIN -> outputs 0 immediately (before next edge), no done; new run afterward gives correct statistics.
REQ-038 SHALL cover: a=16'h0F0F,b=16'hF0F0,approx=16'h0000 -> ed=65535 (approx below exact), err_count=1.
